// File: rtl/l2_mem_request_buffer.sv
// l2_mem_request_buffer: one-transaction command/data buffer between L2 and external memory.
// Optional transaction counters are built when L2_MEM_BUFFER_PERF_EN is defined.
module l2_mem_request_buffer #(
   parameter int BW_ADDR  = 24,
   parameter int BW_BLOCK = 4
) (
   input  logic               clock_i,
   input  logic               resetn_i,
   input  logic               req_i,
   input  logic               req_block_i,
   input  logic               rw_i,
   input  logic [BW_ADDR-1:0] add_i,
   output logic               ready_req_o,
   input  logic               write_i,
   input  logic [31:0]        wdata_i,
   output logic               ready_write_o,
   input  logic               read_i,
   output logic [31:0]        rdata_o,
   output logic               ready_read_o,
   output logic               ext_req_o,
   output logic               ext_rw_o,
   output logic               ext_block_o,
   output logic [BW_ADDR-1:0] ext_add_o,
   input  logic               ext_ack_i,
   output logic               ext_wvalid_o,
   output logic [31:0]        ext_wdata_o,
   input  logic               ext_wready_i,
   input  logic               ext_rvalid_i,
   input  logic [31:0]        ext_rdata_i,
   output logic               err_o,
   output logic [31:0]        perf_rd_o,
   output logic [31:0]        perf_wr_o
);

   localparam int DEPTH = 1 << BW_BLOCK;
   localparam logic [BW_BLOCK:0] ONE     = {{BW_BLOCK{1'b0}}, 1'b1};
   localparam logic [BW_BLOCK:0] N_BLOCK = {1'b1, {BW_BLOCK{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WFILL,
      S_WISSUE,
      S_WDATA,
      S_RISSUE,
      S_RDATA
   } state_t;

   state_t state;

   logic               lat_rw;
   logic               lat_block;
   logic [BW_ADDR-1:0] lat_add;
   logic [BW_BLOCK:0]  n_words;
   logic [BW_BLOCK:0]  xfer;
   logic [BW_BLOCK:0]  xfer_inc;
   logic               last;

   logic [31:0]         wmem [DEPTH];
   logic [BW_BLOCK-1:0] wwp;
   logic [BW_BLOCK-1:0] wrp;
   logic [BW_BLOCK:0]   wcnt;

   logic [31:0]         rmem [DEPTH];
   logic [BW_BLOCK-1:0] rwp;
   logic [BW_BLOCK-1:0] rrp;
   logic [BW_BLOCK:0]   rcnt;

   logic accept;
   logic wpush;
   logic wpop;
   logic rfill_ok;
   logic rpush;
   logic rpop;
   logic err;

   assign xfer_inc = xfer + ONE;
   assign last     = (xfer_inc == n_words);

   assign ready_req_o   = (state == S_IDLE) & (rcnt == '0);
   assign accept        = req_i & ready_req_o;
   assign ready_write_o = (state == S_WFILL) & (xfer < n_words);
   assign wpush         = write_i & ready_write_o;
   assign ext_wvalid_o  = (state == S_WDATA) & (wcnt != '0);
   assign wpop          = ext_wvalid_o & ext_wready_i;
   assign rfill_ok      = (state == S_RDATA) & (xfer < n_words);
   assign rpush         = ext_rvalid_i & rfill_ok;
   assign ready_read_o  = (rcnt != '0);
   assign rpop          = read_i & ready_read_o;

   assign ext_req_o   = (state == S_WISSUE) | (state == S_RISSUE);
   assign ext_rw_o    = lat_rw;
   assign ext_block_o = lat_block;
   assign ext_add_o   = lat_add;
   assign err_o       = err;

   // Heads are masked so both data outputs read zero while their FIFO is empty.
   assign rdata_o     = ready_read_o ? rmem[rrp] : '0;
   assign ext_wdata_o = ext_wvalid_o ? wmem[wrp] : '0;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state     <= S_IDLE;
         lat_rw    <= 1'b0;
         lat_block <= 1'b0;
         lat_add   <= '0;
         n_words   <= '0;
         xfer      <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  lat_rw    <= rw_i;
                  lat_block <= req_block_i;
                  lat_add   <= add_i;
                  n_words   <= req_block_i ? N_BLOCK : ONE;
                  xfer      <= '0;
                  state     <= rw_i ? S_WFILL : S_RISSUE;
               end
            end
            S_WFILL: begin
               if (wpush) begin
                  xfer <= last ? '0 : xfer_inc;
                  if (last) state <= S_WISSUE;
               end
            end
            S_WISSUE: begin
               if (ext_ack_i) state <= S_WDATA;
            end
            S_WDATA: begin
               if (wpop) begin
                  xfer <= last ? '0 : xfer_inc;
                  if (last) state <= S_IDLE;
               end
            end
            S_RISSUE: begin
               if (ext_ack_i) begin
                  xfer  <= '0;
                  state <= S_RDATA;
               end
            end
            S_RDATA: begin
               if (rpush) begin
                  xfer <= last ? '0 : xfer_inc;
                  if (last) state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (wpush) wmem[wwp] <= wdata_i;
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         wwp  <= '0;
         wrp  <= '0;
         wcnt <= '0;
      end else begin
         if (wpush) wwp <= wwp + 1'b1;
         if (wpop)  wrp <= wrp + 1'b1;
         unique case ({wpush, wpop})
            2'b10:   wcnt <= wcnt + ONE;
            2'b01:   wcnt <= wcnt - ONE;
            default: wcnt <= wcnt;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (rpush) rmem[rwp] <= ext_rdata_i;
   end

   // Push and pop may coincide while L2 drains during the fill.
   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         rwp  <= '0;
         rrp  <= '0;
         rcnt <= '0;
      end else begin
         if (rpush) rwp <= rwp + 1'b1;
         if (rpop)  rrp <= rrp + 1'b1;
         unique case ({rpush, rpop})
            2'b10:   rcnt <= rcnt + ONE;
            2'b01:   rcnt <= rcnt - ONE;
            default: rcnt <= rcnt;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         err <= 1'b0;
      end else if ((write_i & ~ready_write_o) | (ext_rvalid_i & ~rfill_ok)) begin
         err <= 1'b1;
      end
   end

`ifdef L2_MEM_BUFFER_PERF_EN
   logic [31:0] perf_rd;
   logic [31:0] perf_wr;
   logic        rd_done;
   logic        wr_done;

   assign rd_done = (state == S_RDATA) & rpush & last;
   assign wr_done = (state == S_WDATA) & wpop & last;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         perf_rd <= '0;
         perf_wr <= '0;
      end else begin
         if (rd_done && perf_rd != '1) perf_rd <= perf_rd + 32'd1;
         if (wr_done && perf_wr != '1) perf_wr <= perf_wr + 32'd1;
      end
   end

   assign perf_rd_o = perf_rd;
   assign perf_wr_o = perf_wr;
`else
   assign perf_rd_o = '0;
   assign perf_wr_o = '0;
`endif

endmodule

// File: tb/tb_l2_mem_request_buffer.sv
// tb_l2_mem_request_buffer: directed bench for l2_mem_request_buffer.
// Expected perf counts follow L2_MEM_BUFFER_PERF_EN.
module tb_l2_mem_request_buffer;

   localparam int NB = 16;

   logic        clock_i = 1'b0;
   logic        resetn_i = 1'b0;
   logic        req_i = 1'b0;
   logic        req_block_i = 1'b0;
   logic        rw_i = 1'b0;
   logic [23:0] add_i = '0;
   logic        ready_req_o;
   logic        write_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic        ready_write_o;
   logic        read_i = 1'b0;
   logic [31:0] rdata_o;
   logic        ready_read_o;
   logic        ext_req_o;
   logic        ext_rw_o;
   logic        ext_block_o;
   logic [23:0] ext_add_o;
   logic        ext_ack_i = 1'b0;
   logic        ext_wvalid_o;
   logic [31:0] ext_wdata_o;
   logic        ext_wready_i = 1'b0;
   logic        ext_rvalid_i = 1'b0;
   logic [31:0] ext_rdata_i = '0;
   logic        err_o;
   logic [31:0] perf_rd_o;
   logic [31:0] perf_wr_o;

   int tests = 0;
   int fails = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   l2_mem_request_buffer #(.BW_ADDR(24), .BW_BLOCK(4)) dut (
      .clock_i(clock_i), .resetn_i(resetn_i),
      .req_i(req_i), .req_block_i(req_block_i), .rw_i(rw_i),
      .add_i(add_i), .ready_req_o(ready_req_o),
      .write_i(write_i), .wdata_i(wdata_i), .ready_write_o(ready_write_o),
      .read_i(read_i), .rdata_o(rdata_o), .ready_read_o(ready_read_o),
      .ext_req_o(ext_req_o), .ext_rw_o(ext_rw_o), .ext_block_o(ext_block_o),
      .ext_add_o(ext_add_o), .ext_ack_i(ext_ack_i),
      .ext_wvalid_o(ext_wvalid_o), .ext_wdata_o(ext_wdata_o),
      .ext_wready_i(ext_wready_i),
      .ext_rvalid_i(ext_rvalid_i), .ext_rdata_i(ext_rdata_i),
      .err_o(err_o), .perf_rd_o(perf_rd_o), .perf_wr_o(perf_wr_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [31:0] pexp(input int v);
`ifdef L2_MEM_BUFFER_PERF_EN
      return 32'(v);
`else
      return (v == 0) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic issue(input logic rw, input logic blk, input logic [23:0] a);
      req_i = 1'b1;
      rw_i = rw;
      req_block_i = blk;
      add_i = a;
      step();
      req_i = 1'b0;
   endtask

   task automatic ack();
      ext_ack_i = 1'b1;
      step();
      ext_ack_i = 1'b0;
   endtask

   task automatic test_reset();
      resetn_i = 1'b0;
      repeat (2) step();
      tests++;
      if ({ready_req_o, err_o, ready_write_o, ready_read_o, ext_req_o, ext_wvalid_o} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_flags got %b want 100000",
            {ready_req_o, err_o, ready_write_o, ready_read_o, ext_req_o, ext_wvalid_o});
      end
      tests++;
      if ({rdata_o, ext_wdata_o} !== 64'd0) begin
         fails++;
         $display("FAIL reset_data got %h %h want 0", rdata_o, ext_wdata_o);
      end
      tests++;
      if ({ext_rw_o, ext_block_o, ext_add_o} !== 26'd0) begin
         fails++;
         $display("FAIL reset_cmd got %b %b %h want 0", ext_rw_o, ext_block_o, ext_add_o);
      end
      tests++;
      if ({perf_rd_o, perf_wr_o} !== 64'd0) begin
         fails++;
         $display("FAIL reset_perf got %h %h want 0", perf_rd_o, perf_wr_o);
      end
      resetn_i = 1'b1;
      step();
      tests++;
      if (ready_req_o !== 1'b1) begin
         fails++;
         $display("FAIL post_reset_ready got %b want 1", ready_req_o);
      end
   endtask

   task automatic test_block_read();
      logic [31:0] e;
      issue(1'b0, 1'b1, 24'h000120);
      tests++;
      if ({ext_req_o, ext_rw_o, ext_block_o, ext_add_o} !== {3'b101, 24'h000120}) begin
         fails++;
         $display("FAIL rd_cmd got %b%b%b %h want 101 000120", ext_req_o, ext_rw_o, ext_block_o, ext_add_o);
      end
      step();
      step();
      tests++;
      if ({ext_req_o, ext_add_o} !== {1'b1, 24'h000120}) begin
         fails++;
         $display("FAIL rd_cmd_hold got %b %h want 1 000120", ext_req_o, ext_add_o);
      end
      ack();
      tests++;
      if (ext_req_o !== 1'b0) begin
         fails++;
         $display("FAIL rd_ack_drop got %b want 0", ext_req_o);
      end
      for (int i = 0; i < NB; i++) begin
         ext_rvalid_i = 1'b1;
         ext_rdata_i = 32'hA0 + 32'(i);
         step();
      end
      ext_rvalid_i = 1'b0;
      exp_rd++;
      for (int i = 0; i < NB; i++) begin
         e = 32'hA0 + 32'(i);
         tests++;
         if (rdata_o !== e || ready_read_o !== 1'b1) begin
            fails++;
            $display("FAIL rd_word%0d got %h/%b want %h/1", i, rdata_o, ready_read_o, e);
         end
         tests++;
         if (ready_req_o !== 1'b0) begin
            fails++;
            $display("FAIL rd_early_ready%0d got %b want 0", i, ready_req_o);
         end
         read_i = 1'b1;
         step();
      end
      read_i = 1'b0;
      tests++;
      if ({ready_req_o, ready_read_o} !== 2'b10) begin
         fails++;
         $display("FAIL rd_done got %b%b want 10", ready_req_o, ready_read_o);
      end
      tests++;
      if (perf_rd_o !== pexp(exp_rd)) begin
         fails++;
         $display("FAIL rd_perf got %0d want %0d", perf_rd_o, pexp(exp_rd));
      end
   endtask

   task automatic test_single_write();
      issue(1'b1, 1'b0, 24'h00003F);
      tests++;
      if ({ready_write_o, ext_req_o} !== 2'b10) begin
         fails++;
         $display("FAIL sw_fill got %b%b want 10", ready_write_o, ext_req_o);
      end
      write_i = 1'b1;
      wdata_i = 32'hDEADBEEF;
      step();
      write_i = 1'b0;
      tests++;
      if (ready_write_o !== 1'b0) begin
         fails++;
         $display("FAIL sw_ready_drop got %b want 0", ready_write_o);
      end
      tests++;
      if ({ext_req_o, ext_rw_o, ext_block_o, ext_add_o} !== {3'b110, 24'h00003F}) begin
         fails++;
         $display("FAIL sw_cmd got %b%b%b %h want 110 00003f", ext_req_o, ext_rw_o, ext_block_o, ext_add_o);
      end
      ack();
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({ext_wvalid_o, ext_wdata_o} !== {1'b1, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL sw_hold%0d got %b %h want 1 deadbeef", i, ext_wvalid_o, ext_wdata_o);
         end
         step();
      end
      ext_wready_i = 1'b1;
      step();
      ext_wready_i = 1'b0;
      exp_wr++;
      tests++;
      if ({ext_wvalid_o, ready_req_o, err_o} !== 3'b010) begin
         fails++;
         $display("FAIL sw_done got %b%b%b want 010", ext_wvalid_o, ready_req_o, err_o);
      end
      tests++;
      if (perf_wr_o !== pexp(exp_wr)) begin
         fails++;
         $display("FAIL sw_perf got %0d want %0d", perf_wr_o, pexp(exp_wr));
      end
   endtask

   task automatic test_block_write_toggle();
      int idx;
      int cyc;
      logic [31:0] e;
      issue(1'b1, 1'b1, 24'h000400);
      for (int i = 0; i < NB; i++) begin
         write_i = 1'b1;
         wdata_i = 32'hB0 + 32'(i);
         step();
      end
      write_i = 1'b0;
      tests++;
      if ({ready_write_o, ext_req_o, ext_block_o} !== 3'b011) begin
         fails++;
         $display("FAIL bw_issue got %b%b%b want 011", ready_write_o, ext_req_o, ext_block_o);
      end
      ack();
      idx = 0;
      cyc = 0;
      while (idx < NB && cyc < 200) begin
         ext_wready_i = (cyc % 2 == 1);
         if (ext_wvalid_o && ext_wready_i) begin
            e = 32'hB0 + 32'(idx);
            tests++;
            if (ext_wdata_o !== e) begin
               fails++;
               $display("FAIL bw_word%0d got %h want %h", idx, ext_wdata_o, e);
            end
            idx++;
         end
         step();
         cyc++;
      end
      ext_wready_i = 1'b0;
      exp_wr++;
      tests++;
      if (idx != NB) begin
         fails++;
         $display("FAIL bw_timeout got %0d words want %0d", idx, NB);
      end
      tests++;
      if ({ext_wvalid_o, ready_req_o} !== 2'b01) begin
         fails++;
         $display("FAIL bw_done got %b%b want 01", ext_wvalid_o, ready_req_o);
      end
      tests++;
      if (perf_wr_o !== pexp(exp_wr)) begin
         fails++;
         $display("FAIL bw_perf got %0d want %0d", perf_wr_o, pexp(exp_wr));
      end
   endtask

   task automatic test_overlap_read();
      logic [31:0] e;
      issue(1'b0, 1'b1, 24'h000200);
      ack();
      for (int i = 0; i < NB; i++) begin
         ext_rvalid_i = 1'b1;
         ext_rdata_i = 32'hC0 + 32'(i);
         read_i = (i > 0);
         step();
         e = 32'hC0 + 32'(i);
         tests++;
         if ({ready_read_o, rdata_o} !== {1'b1, e}) begin
            fails++;
            $display("FAIL ov_head%0d got %b %h want 1 %h", i, ready_read_o, rdata_o, e);
         end
      end
      ext_rvalid_i = 1'b0;
      read_i = 1'b1;
      step();
      read_i = 1'b0;
      exp_rd++;
      tests++;
      if ({ready_read_o, ready_req_o, err_o} !== 3'b010) begin
         fails++;
         $display("FAIL ov_done got %b%b%b want 010", ready_read_o, ready_req_o, err_o);
      end
      tests++;
      if (perf_rd_o !== pexp(exp_rd)) begin
         fails++;
         $display("FAIL ov_perf got %0d want %0d", perf_rd_o, pexp(exp_rd));
      end
   endtask

   task automatic test_errors();
      logic [31:0] e;
      issue(1'b0, 1'b1, 24'h000300);
      ack();
      for (int i = 0; i < NB + 1; i++) begin
         ext_rvalid_i = 1'b1;
         ext_rdata_i = 32'hE0 + 32'(i);
         step();
         if (i == NB - 1) begin
            tests++;
            if (err_o !== 1'b0) begin
               fails++;
               $display("FAIL er_early got %b want 0", err_o);
            end
         end
      end
      ext_rvalid_i = 1'b0;
      exp_rd++;
      tests++;
      if (err_o !== 1'b1) begin
         fails++;
         $display("FAIL er_overrun got %b want 1", err_o);
      end
      for (int i = 0; i < NB; i++) begin
         e = 32'hE0 + 32'(i);
         tests++;
         if (rdata_o !== e) begin
            fails++;
            $display("FAIL er_word%0d got %h want %h", i, rdata_o, e);
         end
         read_i = 1'b1;
         step();
      end
      read_i = 1'b0;
      tests++;
      if ({ready_read_o, err_o} !== 2'b01) begin
         fails++;
         $display("FAIL er_dropped got %b%b want 01", ready_read_o, err_o);
      end
      resetn_i = 1'b0;
      step();
      resetn_i = 1'b1;
      exp_rd = 0;
      exp_wr = 0;
      step();
      tests++;
      if (err_o !== 1'b0) begin
         fails++;
         $display("FAIL er_clear got %b want 0", err_o);
      end
      ext_rvalid_i = 1'b1;
      ext_rdata_i = 32'h55;
      step();
      ext_rvalid_i = 1'b0;
      repeat (3) step();
      tests++;
      if ({err_o, ready_read_o, ready_req_o} !== 3'b101) begin
         fails++;
         $display("FAIL er_idle got %b%b%b want 101", err_o, ready_read_o, ready_req_o);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] e;
      issue(1'b0, 1'b1, 24'h000500);
      ack();
      for (int i = 0; i < 7; i++) begin
         ext_rvalid_i = 1'b1;
         ext_rdata_i = 32'h70 + 32'(i);
         step();
      end
      ext_rdata_i = 32'h77;
      #2;
      resetn_i = 1'b0;
      #1;
      tests++;
      if ({ready_req_o, err_o, ready_read_o, ext_req_o, ext_wvalid_o} !== 5'b10000) begin
         fails++;
         $display("FAIL mr_flags got %b want 10000",
            {ready_req_o, err_o, ready_read_o, ext_req_o, ext_wvalid_o});
      end
      tests++;
      if ({rdata_o, ext_add_o} !== 56'd0) begin
         fails++;
         $display("FAIL mr_data got %h %h want 0", rdata_o, ext_add_o);
      end
      ext_rvalid_i = 1'b0;
      step();
      resetn_i = 1'b1;
      exp_rd = 0;
      exp_wr = 0;
      step();
      issue(1'b0, 1'b1, 24'h000600);
      tests++;
      if ({ext_req_o, ext_add_o} !== {1'b1, 24'h000600}) begin
         fails++;
         $display("FAIL mr_cmd got %b %h want 1 000600", ext_req_o, ext_add_o);
      end
      ack();
      for (int i = 0; i < NB; i++) begin
         ext_rvalid_i = 1'b1;
         ext_rdata_i = 32'hD0 + 32'(i);
         step();
      end
      ext_rvalid_i = 1'b0;
      exp_rd++;
      for (int i = 0; i < NB; i++) begin
         e = 32'hD0 + 32'(i);
         tests++;
         if (rdata_o !== e) begin
            fails++;
            $display("FAIL mr_word%0d got %h want %h", i, rdata_o, e);
         end
         read_i = 1'b1;
         step();
      end
      read_i = 1'b0;
      tests++;
      if ({ready_req_o, ready_read_o, err_o} !== 3'b100) begin
         fails++;
         $display("FAIL mr_done got %b%b%b want 100", ready_req_o, ready_read_o, err_o);
      end
      tests++;
      if (perf_rd_o !== pexp(exp_rd)) begin
         fails++;
         $display("FAIL mr_perf got %0d want %0d", perf_rd_o, pexp(exp_rd));
      end
   endtask

   initial begin
      test_reset();
      test_block_read();
      test_single_write();
      test_block_write_toggle();
      test_overlap_read();
      test_errors();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
